// File: rtl/alu_seq_param.sv
// alu_seq_param: registered execute-stage ALU with iterative unsigned multiply/divide.
// Macro ALU_MULDIV_EN builds the RUN state for MULU/DIVU; without it those ops are illegal.
module alu_seq_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;

    if (WIDTH < 4 || (2 ** CNT_W) <= WIDTH) begin : g_bad_params
        $error("alu_seq_param: WIDTH must be >= 4 and CNT_W must hold WIDTH");
    end

    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_err;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic             w_mc;

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MULU = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_RUN   = 1'b1;

    logic             r_state;
    logic             r_busy;
    logic             r_is_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mq_nx;

    // Multiply: acc:mq shifts right, adding the multiplicand when mq[0] is set.
    assign w_msum  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_dvs} : {(WIDTH+1){1'b0}});
    // Divide: remainder shifts left taking the next dividend bit, restored if negative.
    assign w_rsh   = {r_acc, r_mq[WIDTH-1]};
    assign w_trial = {1'b0, w_rsh} - {2'b00, r_dvs};
    assign w_ge    = ~w_trial[WIDTH+1];

    assign w_acc_nx = r_is_div ? (w_ge ? w_trial[WIDTH-1:0] : w_rsh[WIDTH-1:0]) : w_msum[WIDTH:1];
    assign w_mq_nx  = r_is_div ? {r_mq[WIDTH-2:0], w_ge} : {w_msum[0], r_mq[WIDTH-1:1]};

    assign busy = r_busy;
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        w_mc  = 1'b0;
        case (op)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_MULDIV_EN
            OP_MULU: w_mc = 1'b1;
            OP_DIVU: begin
                w_mc  = (b != '0);
                w_res = '1;
                w_hi  = a;
                w_err = (b == '0);
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_result   <= '0;
            r_hi       <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
`ifdef ALU_MULDIV_EN
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_is_div   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mq       <= '0;
            r_dvs      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef ALU_MULDIV_EN
            if (r_state == S_RUN) begin
                r_acc <= w_acc_nx;
                r_mq  <= w_mq_nx;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_result   <= w_mq_nx;
                    r_hi       <= w_acc_nx;
                    r_zero     <= (w_mq_nx == '0);
                    r_carry    <= 1'b0;
                    r_overflow <= 1'b0;
                    r_err      <= 1'b0;
                end
            end else if (start && w_mc) begin
                r_state  <= S_RUN;
                r_busy   <= 1'b1;
                r_is_div <= (op == OP_DIVU);
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mq     <= a;
                r_dvs    <= b;
            end else
`endif
            if (start) begin
                r_done     <= 1'b1;
                r_result   <= w_res;
                r_hi       <= w_hi;
                r_zero     <= (w_res == '0);
                r_carry    <= w_c;
                r_overflow <= w_v;
                r_err      <= w_err;
            end
        end
    end

    assign done     = r_done;
    assign result   = r_result;
    assign hi       = r_hi;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign err      = r_err;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: scoreboard bench for alu_seq_param; expectations follow ALU_MULDIV_EN.
module tb_alu_seq_param;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, carry, overflow, err;
    logic [W-1:0] result, hi;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] h;
        logic         z, c, v, e;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi),
        .zero(zero), .carry(carry), .overflow(overflow), .err(err)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        logic [W:0] s;
        logic [2*W-1:0] p;
        e.r = '0; e.h = '0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0; e.lat = 1;
        case (o)
            4'd0: e.r = x & y;
            4'd1: e.r = x | y;
            4'd3: e.r = x ^ y;
            4'd4: e.r = ~(x | y);
            4'd2: begin
                s = {1'b0, x} + {1'b0, y};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            4'd6: begin
                e.r = x - y;
                e.c = (x >= y);
                e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            4'd7: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd8: e.r = (x < y) ? 1 : 0;
`ifdef ALU_MULDIV_EN
            4'd9: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.r = p[W-1:0];
                e.h = p[2*W-1:W];
                e.lat = W + 1;
            end
            4'd10: begin
                if (y == '0) begin
                    e.r = '1; e.h = x; e.e = 1'b1;
                end else begin
                    e.r = x / y; e.h = x % y; e.lat = W + 1;
                end
            end
`endif
            default: e.e = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Caller is at a negedge; returns one negedge later (cycle N+1) with inputs scrambled.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        op = 4'($urandom_range(15, 0));
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(input string name, input int n0);
        int   n = n0;
        exp_t e;
        while (done !== 1'b1 && n < W + 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done not seen after %0d cycles", name, n);
            if (sb.size() > 0) sb.delete(0);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected done with empty scoreboard", name);
            return;
        end
        e = sb.pop_front();
        last = e;
        checks++; if (n !== e.lat)     begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, e.lat); end
        checks++; if (result !== e.r)  begin errors++; $display("FAIL %s result got %h want %h", name, result, e.r); end
        checks++; if (hi !== e.h)      begin errors++; $display("FAIL %s hi got %h want %h", name, hi, e.h); end
        checks++; if (zero !== e.z)    begin errors++; $display("FAIL %s zero got %b want %b", name, zero, e.z); end
        checks++; if (carry !== e.c)   begin errors++; $display("FAIL %s carry got %b want %b", name, carry, e.c); end
        checks++; if (overflow !== e.v) begin errors++; $display("FAIL %s overflow got %b want %b", name, overflow, e.v); end
        checks++; if (err !== e.e)     begin errors++; $display("FAIL %s err got %b want %b", name, err, e.e); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL %s busy at done got %b want 0", name, busy); end
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(o, x, y);
        wait_done(name, 1);
    endtask

    task automatic check_all_zero(input string name);
        logic [2*W+5:0] v;
        v = {busy, done, result, hi, zero, carry, overflow, err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s outputs got busy=%b done=%b result=%h hi=%h z=%b c=%b v=%b err=%b want all 0",
                     name, busy, done, result, hi, zero, carry, overflow, err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_sub_slt;
        run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1);
        run_op("add_carry", 4'd2, 32'hFFFF_FFFF, 32'h1);
        run_op("sub_eq", 4'd6, 32'd5, 32'd5);
        run_op("sub_borrow", 4'd6, 32'd3, 32'd9);
        run_op("sub_ovf", 4'd6, 32'h8000_0000, 32'h1);
        run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h1);
        run_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'h1);
    endtask

    task automatic test_logic;
        run_op("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run_op("or", 4'd1, 32'hF0F0_0000, 32'h0000_1234);
        run_op("xor", 4'd3, 32'hAAAA_5555, 32'hFFFF_0000);
        run_op("nor", 4'd4, 32'hFFFF_0000, 32'h0000_FFFF);
    endtask

    task automatic test_mulu;
        issue(4'd9, 32'hFFFF_FFFF, 32'h2);
`ifdef ALU_MULDIV_EN
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mulu busy at N+1 got %b want 1", busy); end
        repeat (3) @(negedge clk);
        start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("mulu", 5);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mulu ignored_start got done=%b want 0", done); end
`else
        wait_done("mulu", 1);
`endif
    endtask

    task automatic test_divu;
        run_op("divu", 4'd10, 32'd100, 32'd7);
        run_op("divu_zero", 4'd10, 32'd100, 32'd0);
        run_op("divu_big", 4'd10, 32'hFFFF_FFFF, 32'h0001_0000);
        run_op("divu_small", 4'd10, 32'd3, 32'd10);
    endtask

    task automatic test_illegal_back_to_back;
        run_op("illegal5", 4'd5, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("b2b_add", 4'd2, 32'd3, 32'd4);
        for (int i = 11; i < 16; i++)
            run_op("illegal_hi", 4'(i), $urandom, $urandom);
    endtask

    task automatic test_hold;
        run_op("hold_xor", 4'd3, 32'h1357_9BDF, 32'h0F0F_0F0F);
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== last.r || hi !== last.h) begin
            errors++;
            $display("FAIL hold got done=%b result=%h hi=%h want 0 %h %h", done, result, hi, last.r, last.h);
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        start = 1'b1; op = 4'd9; a = 32'h1234_5678; b = 32'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset_mid");
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid got done after abort want none"); end
        run_op("after_reset_add", 4'd2, 32'd10, 32'd20);
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? (x >> $urandom_range(31, 0)) : $urandom;
            run_op("random", 4'($urandom_range(15, 0)), x, y);
        end
    endtask

    initial begin
        test_reset;
        test_add_sub_slt;
        test_logic;
        test_mulu;
        test_divu;
        test_illegal_back_to_back;
        test_hold;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
